// File: rtl/fc_layer_seq.sv
// Sequential fully-connected layer: one multiply-accumulate per cycle, bias loaded first per neuron.
// Define FC_RELU_EN to clamp negative neuron results to zero.
module fc_layer_seq #(
  parameter int N_IN  = 30,
  parameter int N_OUT = 8,
  parameter int DW    = 24,
  parameter int WW    = 16,
  parameter int ACC_W = 40,
  parameter int FRAC  = 8,
  localparam int AW = (N_OUT * N_IN > 1) ? $clog2(N_OUT * N_IN) : 1,
  localparam int BW = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic signed [DW-1:0] i_data [0:N_IN-1],
  output logic [AW-1:0]        o_w_addr,
  input  logic signed [WW-1:0] i_w_data,
  output logic [BW-1:0]        o_b_addr,
  input  logic signed [WW-1:0] i_b_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic signed [31:0]   o_output,
  output logic [BW-1:0]        o_idx,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
  localparam logic [BW-1:0] J_LAST = BW'(N_OUT - 1);

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, OUT} state_t;

  state_t                   state_q;
  logic [KW-1:0]            k_q;
  logic signed [DW-1:0]     data_q [0:N_IN-1];
  logic signed [DW+WW-1:0]  prod_q;
  logic signed [DW+WW-1:0]  prod_d;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  bias_ext;
  logic signed [31:0]       result_d;

  // Product is registered and folded into the accumulator one cycle later.
  assign prod_d   = data_q[k_q] * i_w_data;
  assign prod_ext = ACC_W'(prod_q);
  assign bias_ext = ACC_W'(i_b_data) <<< FRAC;
  assign acc_d    = acc_q + prod_ext;

  always_comb begin
    result_d = 32'(acc_d >>> FRAC);
`ifdef FC_RELU_EN
    if (acc_d[ACC_W-1]) result_d = '0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      o_w_addr <= '0;
      o_b_addr <= '0;
      o_valid  <= 1'b0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      o_output <= '0;
      o_idx    <= '0;
      for (int i = 0; i < N_IN; i++) data_q[i] <= '0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            for (int i = 0; i < N_IN; i++) data_q[i] <= i_data[i];
            o_idx    <= '0;
            o_b_addr <= '0;
            o_w_addr <= '0;
            o_busy   <= 1'b1;
            state_q  <= BIAS;
          end
        end
        BIAS: begin
          k_q      <= '0;
          o_w_addr <= o_w_addr + AW'(1);
          state_q  <= MAC;
        end
        MAC: begin
          prod_q <= prod_d;
          acc_q  <= (k_q == '0) ? bias_ext : acc_d;
          // Address stops at the next neuron's base, ready for its BIAS cycle.
          if (k_q == K_LAST) begin
            state_q <= DRAIN;
          end else begin
            k_q      <= k_q + KW'(1);
            o_w_addr <= o_w_addr + AW'(1);
          end
        end
        DRAIN: begin
          acc_q    <= acc_d;
          o_output <= result_d;
          o_valid  <= 1'b1;
          state_q  <= OUT;
        end
        OUT: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            if (o_idx == J_LAST) begin
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              state_q <= IDLE;
            end else begin
              o_idx    <= o_idx + BW'(1);
              o_b_addr <= o_idx + BW'(1);
              state_q  <= BIAS;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
